sync_fifo: RTL and testbench

//  Single-clock first-word-fall-through (FWFT) FIFO.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_mem.sv | 30 +++
 rtl/sync_fifo.sv | 94 +++++++++
 tb/tb_sync_fifo.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared helpers for sync_fifo: pointer wrap and width calculations
package sync_fifo_pkg;

   // Width of a read/write pointer for a given depth
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of the occupancy count, which must be able to hold the value depth itself
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer increment that wraps depth-1 -> 0 (depth need not be a power of two)
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   localparam int PTR_W = ptr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [PTR_W-1:0]  r_addr,
   output logic [DATA_W-1:0] r_data
);

   // Storage is deliberately not reset; only pointers decide what is valid
   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: store the word at the write address on the rising edge
   always_ff @(posedge clk) begin
      if (we) begin
         mem[w_addr] <= w_data;
      end
   end

   // Read port is combinational so the head word falls through immediately
   assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FWFT FIFO; optional checks under SYNC_FIFO_ERR_CHECK_EN
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   localparam int PTR_W = ptr_width(DEPTH),
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              w_req,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_req,
   output logic [DATA_W-1:0] r_data,
   output logic [CNT_W-1:0]  cnt,
   output logic              empty,
   output logic              full
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt_nxt;
   logic             wr_ok;
   logic             rd_ok;

   // A write into a full FIFO is only safe when the head leaves in the same cycle
   assign wr_ok = w_req & (~full | r_req);
   assign rd_ok = r_req & ~empty;

   sync_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk    (clk),
      .we     (wr_ok),
      .w_addr (wr_ptr),
      .w_data (w_data),
      .r_addr (rd_ptr),
      .r_data (r_data)
   );

   // Next occupancy: +1 on write only, -1 on read only, unchanged otherwise
   always_comb begin
      cnt_nxt = cnt;
      case ({wr_ok, rd_ok})
         2'b10:   cnt_nxt = cnt + CNT_W'(1);
         2'b01:   cnt_nxt = cnt - CNT_W'(1);
         default: cnt_nxt = cnt;
      endcase
   end

   // Pointers, count and flags; flags are registered from the next count
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
         end
         if (rd_ok) begin
            rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
         end
         cnt   <= cnt_nxt;
         empty <= (cnt_nxt == '0);
         full  <= (cnt_nxt == CNT_W'(DEPTH));
      end
   end

`ifdef SYNC_FIFO_ERR_CHECK_EN
   // Flag requests that the FIFO has to ignore
   always @(posedge clk) begin
      if (nrst) begin
         if (w_req & full & ~r_req) begin
            $error("sync_fifo overflow: write dropped while full");
         end
         if (r_req & empty) begin
            $error("sync_fifo underflow: read ignored while empty");
         end
      end
   end

   // Occupancy can never exceed the storage size
   cnt_bound_a : assert property (@(posedge clk) disable iff (!nrst) cnt <= CNT_W'(DEPTH))
      else $error("sync_fifo count above depth");
`else
   // No simulation checks in this build; dropped requests are silently ignored
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed scoreboard bench for sync_fifo
module tb_sync_fifo;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 8;

   logic              clk;
   logic              nrst;
   logic              w_req;
   logic [DATA_W-1:0] w_data;
   logic              r_req;
   logic [DATA_W-1:0] r_data;
   logic [3:0]        cnt;
   logic              empty;
   logic              full;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] sb[$];

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clk    (clk),
      .nrst   (nrst),
      .w_req  (w_req),
      .w_data (w_data),
      .r_req  (r_req),
      .r_data (r_data),
      .cnt    (cnt),
      .empty  (empty),
      .full   (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Status checks against the scoreboard occupancy
   task automatic chk_status(input string tag);
      chk({tag, ".cnt"}, 32'(cnt), 32'(sb.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
      chk({tag, ".full"}, 32'(full), 32'(sb.size() == DEPTH));
   endtask

   // Head word must equal the oldest scoreboard entry
   task automatic chk_head(input string tag);
      if (sb.size() > 0) begin
         chk({tag, ".head"}, 32'(r_data), 32'(sb[0]));
      end
   endtask

   // One clock of stimulus: drive at negedge, check head before the edge, status after
   task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] d, input logic r);
      bit wr_acc;
      bit rd_acc;
      @(negedge clk);
      w_req  = w;
      w_data = d;
      r_req  = r;
      #1;
      if (r) chk_head(tag);
      rd_acc = r && (sb.size() > 0);
      wr_acc = w && ((sb.size() < DEPTH) || r);
      @(posedge clk);
      #1;
      if (rd_acc) void'(sb.pop_front());
      if (wr_acc) sb.push_back(d);
      chk_status(tag);
   endtask

   initial begin
      nrst   = 1'b0;
      w_req  = 1'b0;
      w_data = '0;
      r_req  = 1'b0;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      #1;
      chk_status("reset");

      // 1: read while empty is ignored
      step("s1_rd_empty", 1'b0, 8'h00, 1'b1);
      step("s1_idle", 1'b0, 8'h00, 1'b0);

      // 2: three writes then three reads
      step("s2_w0", 1'b1, 8'h11, 1'b0);
      step("s2_w1", 1'b1, 8'h22, 1'b0);
      step("s2_w2", 1'b1, 8'h33, 1'b0);
      chk("s2_head_11", 32'(r_data), 32'h11);
      for (int i = 0; i < 3; i++) step("s2_rd", 1'b0, 8'h00, 1'b1);
      chk("s2_empty", 32'(empty), 32'h1);

      // 3: fill, overflow dropped, drain in order
      for (int i = 0; i < 8; i++) step("s3_fill", 1'b1, 8'hA0 + 8'(i), 1'b0);
      chk("s3_full", 32'(full), 32'h1);
      step("s3_ovf", 1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 8; i++) step("s3_drain", 1'b0, 8'h00, 1'b1);

      // 4: simultaneous read+write while full
      for (int i = 0; i < 8; i++) step("s4_fill", 1'b1, 8'hA0 + 8'(i), 1'b0);
      step("s4_rw_full", 1'b1, 8'h55, 1'b1);
      chk("s4_cnt8", 32'(cnt), 32'h8);
      chk("s4_head_a1", 32'(r_data), 32'hA1);
      for (int i = 0; i < 8; i++) step("s4_drain", 1'b0, 8'h00, 1'b1);

      // 5: simultaneous read+write while empty
      step("s5_rw_empty", 1'b1, 8'h3C, 1'b1);
      chk("s5_cnt1", 32'(cnt), 32'h1);
      chk("s5_head_3c", 32'(r_data), 32'h3C);
      step("s5_drain", 1'b0, 8'h00, 1'b1);

      // 6: asynchronous reset mid-stream
      for (int i = 0; i < 5; i++) step("s6_fill", 1'b1, 8'h60 + 8'(i), 1'b0);
      chk("s6_cnt5", 32'(cnt), 32'h5);
      @(negedge clk);
      w_req = 1'b0;
      r_req = 1'b0;
      #2;
      nrst = 1'b0;
      #1;
      sb.delete();
      chk_status("s6_async_rst");
      @(negedge clk);
      nrst = 1'b1;
      step("s6_w77", 1'b1, 8'h77, 1'b0);
      chk("s6_head_77", 32'(r_data), 32'h77);
      step("s6_drain", 1'b0, 8'h00, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
